spi_fsm_controller: RTL and testbench
=====================================

Name: spi_fsm_controller

Overview:
- Transaction controller for the SPI memory top level; drives the shift-register parallel load, data-memory write enable, address-latch enable and MISO tristate enable.
- Consumes the conditioned chip select, the SCLK positive-edge strobe and the shift-register read/write bit (parallelDataOut[0]).
- Frame format: 7-bit address MSB-first, then R/W bit (1 = read, 0 = write), then 8 data bits.

Parameters:
- CNT_BITS, 4, width of the SCLK edge counter; must hold the value 8.
- FRAME_BITS, 8, SCLK posedges per phase (address phase and data phase).

Ports:
- clk  input  1  FPGA system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cs  input  1  conditioned chip select, active-low.
- sclk_posedge  input  1  one-clk strobe per SCLK rising edge.
- rw_bit  input  1  shift-register parallelDataOut[0]; valid in GOT state.
- sr_we  output  1  shift-register parallelLoad.
- dm_we  output  1  data-memory writeEnable.
- addr_we  output  1  address-latch enable.
- miso_bufe  output  1  MISO tristate enable.
- state_dbg  output  4  state encoding for the leds bus (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset: state=GET, counter=0, all outputs 0.
- Outputs are Moore: registered, decoded from state only, and never combinational from inputs.
- States and transitions:
  - GET: counter increments on each sclk_posedge. On the posedge that makes counter==FRAME_BITS, go to GOT next clk and clear counter.
  - GOT: addr_we=1 for exactly one clk. Next state READ_WAIT if rw_bit=1, WRITE_GET if rw_bit=0.
  - READ_WAIT: one clk for memory read latency; all outputs 0; then READ_LOAD.
  - READ_LOAD: sr_we=1 for exactly one clk; then READ_SEND.
  - READ_SEND: miso_bufe=1. Counter increments on sclk_posedge; at FRAME_BITS go to DONE and clear counter.
  - WRITE_GET: counter increments on sclk_posedge; at FRAME_BITS go to WRITE_MEM and clear counter.
  - WRITE_MEM: dm_we=1 for exactly one clk; then DONE.
  - DONE: all outputs 0; hold until cs=1.
- Chip-select abort: cs=1 in any state forces state=GET and counter=0 on the next clk, and all outputs go to 0. This has priority over every other transition, including the same-cycle 8th sclk_posedge.
- Idle: while cs=1, the FSM stays in GET, the counter stays at 0, and sclk_posedge is ignored.
- Counter: counts only in GET, READ_SEND and WRITE_GET. It saturates logic-free because it is cleared on each phase exit. It never wraps within a phase.
- Pulse guarantees: addr_we, sr_we and dm_we are each asserted for at most one clk per transaction. dm_we is never asserted in a read transaction.
- Reset_n asserted mid-transaction: immediate return to reset values, with no write pulse.
- State encoding (4 bits): GET=0, GOT=1, READ_WAIT=2, READ_LOAD=3, READ_SEND=4, WRITE_GET=5, WRITE_MEM=6, DONE=7.

Optional Feature:
- Macro: SPI_FSM_DEBUG_EN.
- Defined: state_dbg carries the current state encoding, registered with the state.
- Undefined: state_dbg is tied to 4'b0000 and no extra logic is inferred. All other behaviour is identical.

Test Plan:
- Reset then idle: hold reset_n=0, then release with cs=1 and 20 sclk_posedge strobes -> state_dbg=0, all outputs 0 throughout.
- Write transaction: cs=0, 8 posedges with rw_bit=0 at GOT, then 8 posedges -> addr_we high 1 clk; dm_we high exactly 1 clk; state 6 then 7; sr_we and miso_bufe never high.
- Read transaction: cs=0, 8 posedges with rw_bit=1 -> addr_we 1 clk, then one idle clk, then sr_we 1 clk. miso_bufe stays high for exactly 8 posedges, then drops in DONE.
- Abort mid-phase: cs=0, 5 posedges, then cs=1 -> GET and counter=0 next clk. A fresh 8-posedge frame still reaches GOT.
- Simultaneous event: cs=1 on the same clk as the 8th posedge in WRITE_GET -> GET next clk, dm_we never asserted.
- Async reset in READ_SEND: drop reset_n between clk edges -> miso_bufe=0 immediately without waiting for clk; state_dbg=0 with SPI_FSM_DEBUG_EN defined.

Source files
------------

// File: rtl/spi_fsm_controller.sv
// Transaction sequencer for the SPI memory: address phase, R/W decode, data phase, strobes.
// Optional macro SPI_FSM_DEBUG_EN exposes the state register on state_dbg.
//
// state      | meaning
// -----------+------------------------------------------------------------
// GET        | shift in 7-bit address + R/W bit, count SCLK rising edges
// GOT        | latch address (addr_we), branch on rw_bit
// READ_WAIT  | one clk of memory read latency
// READ_LOAD  | parallel-load shift register from memory (sr_we)
// READ_SEND  | drive MISO (miso_bufe) for one data frame
// WRITE_GET  | shift in one data byte from MOSI
// WRITE_MEM  | commit shifted byte to memory (dm_we)
// DONE       | frame finished, wait for chip select release
module spi_fsm_controller #(
  parameter int CNT_BITS   = 4,
  parameter int FRAME_BITS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       sclk_posedge,
  input  logic       rw_bit,
  output logic       sr_we,
  output logic       dm_we,
  output logic       addr_we,
  output logic       miso_bufe,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_GET       = 4'd0,
    S_GOT       = 4'd1,
    S_READ_WAIT = 4'd2,
    S_READ_LOAD = 4'd3,
    S_READ_SEND = 4'd4,
    S_WRITE_GET = 4'd5,
    S_WRITE_MEM = 4'd6,
    S_DONE      = 4'd7
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                sr_we_q, sr_we_d;
  logic                dm_we_q, dm_we_d;
  logic                addr_we_q, addr_we_d;
  logic                miso_bufe_q, miso_bufe_d;
  logic                frame_end;

  // The edge that completes a phase is the one seen while the count is FRAME_BITS-1.
  assign frame_end = sclk_posedge && (cnt_q == CNT_BITS'(FRAME_BITS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cs) begin
      state_d = S_GET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_GET, S_WRITE_GET, S_READ_SEND: begin
          if (frame_end) begin
            cnt_d = '0;
            if (state_q == S_GET)            state_d = S_GOT;
            else if (state_q == S_WRITE_GET) state_d = S_WRITE_MEM;
            else                             state_d = S_DONE;
          end else if (sclk_posedge) begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        S_GOT:       state_d = rw_bit ? S_READ_WAIT : S_WRITE_GET;
        S_READ_WAIT: state_d = S_READ_LOAD;
        S_READ_LOAD: state_d = S_READ_SEND;
        S_WRITE_MEM: state_d = S_DONE;
        S_DONE:      state_d = S_DONE;
        default: begin
          state_d = S_GET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are flopped from the next state so they line up with state_q exactly.
  always_comb begin
    sr_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    addr_we_d   = 1'b0;
    miso_bufe_d = 1'b0;
    case (state_d)
      S_GOT:       addr_we_d   = 1'b1;
      S_READ_LOAD: sr_we_d     = 1'b1;
      S_READ_SEND: miso_bufe_d = 1'b1;
      S_WRITE_MEM: dm_we_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_GET;
      cnt_q       <= '0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      addr_we_q   <= 1'b0;
      miso_bufe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_we_q     <= sr_we_d;
      dm_we_q     <= dm_we_d;
      addr_we_q   <= addr_we_d;
      miso_bufe_q <= miso_bufe_d;
    end
  end

  assign sr_we     = sr_we_q;
  assign dm_we     = dm_we_q;
  assign addr_we   = addr_we_q;
  assign miso_bufe = miso_bufe_q;

`ifdef SPI_FSM_DEBUG_EN
  assign state_dbg = state_q;
`else
  assign state_dbg = 4'b0000;
`endif

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Directed plus randomized bench for spi_fsm_controller against a transaction-phase model.
module tb_spi_fsm_controller;

  localparam int FB = 8;
  localparam int PH_ADDR = 0, PH_TURN = 1, PH_DATA = 2, PH_END = 3;

  logic       clk = 1'b0;
  logic       reset_n, cs, sclk_posedge, rw_bit;
  logic       sr_we, dm_we, addr_we, miso_bufe;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // model: phase, edges in phase, clocks in turnaround, clocks in end phase
  int m_ph, m_n, m_t, m_e;
  bit m_rd;
  int n_aw, n_sr, n_dm, n_mi;

  spi_fsm_controller #(.CNT_BITS(4), .FRAME_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .sclk_posedge(sclk_posedge),
    .rw_bit(rw_bit), .sr_we(sr_we), .dm_we(dm_we), .addr_we(addr_we),
    .miso_bufe(miso_bufe), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = PH_ADDR; m_n = 0; m_t = 0; m_e = 0; m_rd = 1'b0;
  endtask

  task automatic m_step(input logic c, input logic s, input logic r);
    if (c) begin
      m_ph = PH_ADDR; m_n = 0;
    end else begin
      case (m_ph)
        PH_ADDR: if (s) begin
          m_n++;
          if (m_n == FB) begin m_n = 0; m_ph = PH_TURN; m_t = 0; end
        end
        PH_TURN: begin
          if (m_t == 0) m_rd = r;
          m_t++;
          // write turnaround: latch only; read adds latency and load clocks
          if (m_t == (m_rd ? 3 : 1)) begin m_ph = PH_DATA; m_n = 0; end
        end
        PH_DATA: if (s) begin
          m_n++;
          if (m_n == FB) begin m_ph = PH_END; m_e = 0; end
        end
        default: if (m_e < 2) m_e++;
      endcase
    end
  endtask

  function automatic logic [3:0] exp_dbg();
`ifdef SPI_FSM_DEBUG_EN
    case (m_ph)
      PH_ADDR: return 4'd0;
      PH_TURN: return 4'(1 + m_t);
      PH_DATA: return m_rd ? 4'd4 : 4'd5;
      default: return (!m_rd && m_e == 0) ? 4'd6 : 4'd7;
    endcase
`else
    return 4'd0;
`endif
  endfunction

  task automatic check_all();
    chk("addr_we",   addr_we,   m_ph == PH_TURN && m_t == 0);
    chk("sr_we",     sr_we,     m_ph == PH_TURN && m_rd && m_t == 2);
    chk("miso_bufe", miso_bufe, m_ph == PH_DATA && m_rd);
    chk("dm_we",     dm_we,     m_ph == PH_END && !m_rd && m_e == 0);
    chk("state_dbg", state_dbg, exp_dbg());
    n_aw += addr_we; n_sr += sr_we; n_dm += dm_we; n_mi += miso_bufe;
  endtask

  task automatic clr_cnt();
    n_aw = 0; n_sr = 0; n_dm = 0; n_mi = 0;
  endtask

  task automatic cyc(input logic c, input logic s, input logic r);
    @(negedge clk);
    cs = c; sclk_posedge = s; rw_bit = r;
    @(posedge clk);
    m_step(c, s, r);
    #1 check_all();
  endtask

  task automatic edges(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, r);
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b1; sclk_posedge = 1'b0; rw_bit = 1'b0;
    m_reset(); clr_cnt();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk) reset_n = 1'b1;

    // idle with cs high: strobes ignored
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1);
    chk("idle_pulses", n_aw + n_sr + n_dm + n_mi, 0);

    // write transaction
    clr_cnt();
    cyc(1'b0, 1'b0, 1'b0);
    edges(FB, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    edges(FB, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("wr_aw_cnt", n_aw, 1);
    chk("wr_dm_cnt", n_dm, 1);
    chk("wr_sr_cnt", n_sr, 0);
    chk("wr_mi_cnt", n_mi, 0);
    cyc(1'b1, 1'b0, 1'b0);

    // read transaction
    clr_cnt();
    edges(FB, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    edges(FB, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("rd_aw_cnt", n_aw, 1);
    chk("rd_sr_cnt", n_sr, 1);
    chk("rd_dm_cnt", n_dm, 0);
    chk("rd_mi_cnt", n_mi, 8);
    cyc(1'b1, 1'b0, 1'b0);

    // abort mid address phase, then a fresh frame
    clr_cnt();
    edges(5, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    edges(FB, 1'b0);
    chk("abort_aw_cnt", n_aw, 1);
    cyc(1'b1, 1'b0, 1'b0);

    // cs rises on the same clk as the 8th write-data edge
    clr_cnt();
    edges(FB, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    edges(FB - 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("simul_dm_cnt", n_dm, 0);

    // async reset during READ_SEND
    edges(FB, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    edges(3, 1'b0);
    chk("pre_rst_miso", miso_bufe, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_miso", miso_bufe, 1'b0);
    chk("async_dbg", state_dbg, 4'd0);
    m_reset();
    check_all();
    @(negedge clk) reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
